// File: rtl/wb_line_slave.sv
// wb_line_slave
// Terminates a 128-bit Wishbone line bus and bridges it to a 16-bit backing
// memory. A read fetches all eight words into the line buffer before a single
// ack. A write stores only the words whose byte-select pair is non-zero. A
// periodic refresh window blocks the memory, and a request that arrives while
// refresh is pending is answered with a retry.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   wb_adr[11:0]            line address (byte address bits [15:4])
//   wb_dat_m[127:0]         write line, word i = bits [16i+15:16i]
//   wb_dat_s[127:0]         read line buffer
//   wb_sel[15:0]            byte lanes, bits [2i+1:2i] belong to word i
//   wb_we, wb_stb, wb_cyc   request qualifiers
//   wb_ack, wb_rty          one-cycle completion / retry pulses
//   mem_address[15:0]       {line, word index, 1'b0}
//   mem_wdata[15:0]         write word
//   mem_byte_enable[1:0]    byte enables for the current word
//   mem_read, mem_write     request, held until mem_resp
//   mem_rdata[15:0]         read word
//   mem_resp                completion of the current word
//
// Memory handshake: mem_read/mem_write stay high with address, data and
// byte enables stable until the cycle in which mem_resp is high; that cycle
// retires the word and the next word's fields appear one cycle later.
module wb_line_slave #(
  parameter int REFRESH_PERIOD = 1024,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [11:0]  wb_adr,
  input  logic [127:0] wb_dat_m,
  output logic [127:0] wb_dat_s,
  input  logic [15:0]  wb_sel,
  input  logic         wb_we,
  input  logic         wb_stb,
  input  logic         wb_cyc,
  output logic         wb_ack,
  output logic         wb_rty,
  output logic [15:0]  mem_address,
  output logic [15:0]  mem_wdata,
  output logic [1:0]   mem_byte_enable,
  output logic         mem_read,
  output logic         mem_write,
  input  logic [15:0]  mem_rdata,
  input  logic         mem_resp
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, ACK, RTY, REFRESH} state_t;

  state_t        state, state_n;
  logic [11:0]   adr_q;
  logic [15:0]   sel_q;
  logic [127:0]  dat_q;
  logic [2:0]    idx;
  logic          abort_q;
  logic [31:0]   ref_cnt;
  logic [31:0]   ref_hold;
  logic          pending;
  logic          req;
  logic          ref_hit;
  logic [3:0]    scan;   // {found, word index} of the next selected word

  // Lowest word index >= from whose select pair is non-zero.
  function automatic logic [3:0] find_sel(input logic [15:0] sel, input logic [3:0] from);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (4'(i) >= from && sel[2*i +: 2] != 2'b00) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign req     = wb_stb & wb_cyc;
  assign ref_hit = (REFRESH_PERIOD != 0) && (ref_cnt == 32'(REFRESH_PERIOD - 1));

  assign mem_address = {adr_q, idx, 1'b0};
  assign mem_wdata   = dat_q[{idx, 4'b0000} +: 16];

  always_comb begin
    state_n         = state;
    scan            = 4'd0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 2'b00;
    case (state)
      IDLE: begin
        scan = find_sel(wb_sel, 4'd0);
        if (pending && req)   state_n = RTY;
        else if (pending)     state_n = REFRESH;
        else if (req) begin
          if (!wb_we)         state_n = READ;
          else if (scan[3])   state_n = WRITE;
          else                state_n = ACK;     // nothing selected
        end
      end
      READ: begin
        mem_read        = 1'b1;
        mem_byte_enable = 2'b11;
        if (mem_resp) begin
          if (abort_q || !wb_cyc) state_n = IDLE;
          else if (idx == 3'd7)   state_n = ACK;
        end
      end
      WRITE: begin
        mem_write       = 1'b1;
        mem_byte_enable = sel_q[{idx, 1'b0} +: 2];
        scan            = find_sel(sel_q, {1'b0, idx} + 4'd1);
        if (mem_resp) begin
          if (abort_q || !wb_cyc) state_n = IDLE;
          else if (!scan[3])      state_n = ACK;
        end
      end
      ACK:     state_n = IDLE;
      RTY:     state_n = REFRESH;
      REFRESH: if (ref_hold + 32'd1 >= 32'(REFRESH_CYCLES)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      adr_q    <= '0;
      sel_q    <= '0;
      dat_q    <= '0;
      idx      <= '0;
      abort_q  <= 1'b0;
      ref_cnt  <= '0;
      ref_hold <= '0;
      pending  <= 1'b0;
      wb_dat_s <= '0;
      wb_ack   <= 1'b0;
      wb_rty   <= 1'b0;
    end else begin
      state  <= state_n;
      wb_ack <= (state_n == ACK);
      wb_rty <= (state_n == RTY);

      if (ref_hit || REFRESH_PERIOD == 0) ref_cnt <= '0;
      else                                ref_cnt <= ref_cnt + 32'd1;

      // A new period expiring on the same edge that ends a refresh wins.
      if (ref_hit)                                   pending <= 1'b1;
      else if (state == REFRESH && state_n == IDLE)  pending <= 1'b0;

      ref_hold <= (state == REFRESH && state_n != IDLE) ? ref_hold + 32'd1 : '0;

      // Once wb_cyc drops, the in-flight word still finishes; remember the
      // abort until that word's mem_resp.
      if (state == READ || state == WRITE) abort_q <= !mem_resp && (abort_q || !wb_cyc);
      else                                 abort_q <= 1'b0;

      case (state)
        IDLE: begin
          if (!pending && req) begin
            adr_q <= wb_adr;
            sel_q <= wb_sel;
            dat_q <= wb_dat_m;
            idx   <= wb_we ? scan[2:0] : 3'd0;
          end
        end
        READ: begin
          if (mem_resp) begin
            wb_dat_s[{idx, 4'b0000} +: 16] <= mem_rdata;
            idx <= idx + 3'd1;
          end
        end
        WRITE: begin
          if (mem_resp) idx <= scan[2:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_line_slave.sv
// Testbench for wb_line_slave: directed line reads/writes against a
// behavioural backing memory with a per-word wait table. Expected memory
// accesses and bus responses are queued at issue time; a monitor pops and
// compares them whenever the DUT retires a memory word or pulses ack/rty.
`timescale 1ns/1ps
module tb_wb_line_slave;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [11:0]  wb_adr = '0;
  logic [127:0] wb_dat_m = '0;
  logic [127:0] wb_dat_s;
  logic [15:0]  wb_sel = '0;
  logic         wb_we = 1'b0;
  logic         wb_stb = 1'b0;
  logic         wb_cyc = 1'b0;
  logic         wb_ack;
  logic         wb_rty;
  logic [15:0]  mem_address;
  logic [15:0]  mem_wdata;
  logic [1:0]   mem_byte_enable;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_rdata = '0;
  logic         mem_resp = 1'b0;

  wb_line_slave #(.REFRESH_PERIOD(16), .REFRESH_CYCLES(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .wb_adr(wb_adr), .wb_dat_m(wb_dat_m), .wb_dat_s(wb_dat_s),
    .wb_sel(wb_sel), .wb_we(wb_we), .wb_stb(wb_stb), .wb_cyc(wb_cyc),
    .wb_ack(wb_ack), .wb_rty(wb_rty),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } mem_exp_t;

  typedef struct packed {
    logic         rty;
    logic [31:0]  at;
    logic         chk_dat;
    logic [127:0] dat;
  } rsp_exp_t;

  mem_exp_t exp_mem[$];
  rsp_exp_t exp_rsp[$];

  int n_checks = 0;
  int n_fail = 0;
  int mem_wait[8];
  logic [15:0] mem_base = '0;
  int t0 = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic push_mem(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [1:0] be);
    mem_exp_t e;
    e.wr = wr; e.addr = addr; e.wdata = wdata; e.be = be;
    exp_mem.push_back(e);
  endtask

  task automatic push_rsp(input logic rty, input int at, input logic chk, input logic [127:0] dat);
    rsp_exp_t r;
    r.rty = rty; r.at = 32'(at); r.chk_dat = chk; r.dat = dat;
    exp_rsp.push_back(r);
  endtask

  // ---------------- backing memory model ----------------
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || !(mem_read || mem_write)) begin
        mem_resp = 1'b0;
        wcnt = 0;
      end else if (wcnt >= mem_wait[mem_address[3:1]]) begin
        mem_resp  = 1'b1;
        mem_rdata = mem_write ? 16'hDEAD : mem_base + {13'd0, mem_address[3:1]};
        wcnt = 0;
      end else begin
        mem_resp = 1'b0;
        wcnt++;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic        p_act, p_resp, act;
    logic [15:0] p_addr, p_wdata;
    logic [1:0]  p_be;
    mem_exp_t    e;
    rsp_exp_t    r;
    p_act = 1'b0; p_resp = 1'b0; p_addr = '0; p_wdata = '0; p_be = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        p_act = 1'b0;
      end else begin
        act = mem_read | mem_write;
        if (act && p_act && !p_resp)
          check("mem_stable", 128'({mem_address, mem_wdata, mem_byte_enable}),
                128'({p_addr, p_wdata, p_be}));
        if (act && mem_resp) begin
          check("mem_expected", 128'(exp_mem.size() > 0), 128'(1));
          if (exp_mem.size() > 0) begin
            e = exp_mem.pop_front();
            check("mem_kind", 128'(mem_write), 128'(e.wr));
            check("mem_addr", 128'(mem_address), 128'(e.addr));
            check("mem_be", 128'(mem_byte_enable), 128'(e.be));
            if (e.wr) check("mem_wdata", 128'(mem_wdata), 128'(e.wdata));
          end
        end
        if (wb_ack || wb_rty) begin
          check("ack_rty_excl", 128'(wb_ack & wb_rty), 128'(0));
          check("rsp_expected", 128'(exp_rsp.size() > 0), 128'(1));
          if (exp_rsp.size() > 0) begin
            r = exp_rsp.pop_front();
            check("rsp_kind", 128'(wb_rty), 128'(r.rty));
            check("rsp_cycle", 128'(cycle), 128'(r.at));
            if (r.chk_dat) check("rsp_dat", wb_dat_s, r.dat);
          end
        end
        p_act = act; p_resp = mem_resp;
        p_addr = mem_address; p_wdata = mem_wdata; p_be = mem_byte_enable;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Asserts reset at a falling edge, checks every output immediately, then
  // releases it at the next falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wb_stb = 1'b0;
    wb_cyc = 1'b0;
    #1;
    check("rst_ack", 128'(wb_ack), 128'(0));
    check("rst_rty", 128'(wb_rty), 128'(0));
    check("rst_mem_rw", 128'({mem_read, mem_write}), 128'(0));
    check("rst_mem_addr", 128'(mem_address), 128'(0));
    check("rst_mem_wdata", 128'(mem_wdata), 128'(0));
    check("rst_mem_be", 128'(mem_byte_enable), 128'(0));
    check("rst_dat_s", wb_dat_s, 128'(0));
    check("leftover_mem", 128'(exp_mem.size()), 128'(0));
    check("leftover_rsp", 128'(exp_rsp.size()), 128'(0));
    exp_mem.delete();
    exp_rsp.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic we, input logic [11:0] adr, input logic [15:0] sel,
                       input logic [127:0] dat);
    @(negedge clk);
    wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat_m = dat;
    wb_stb = 1'b1; wb_cyc = 1'b1;
    t0 = cycle;
  endtask

  task automatic wait_ack(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb_ack && n < budget);
    check("ack_seen", 128'(wb_ack), 128'(1));
    wb_stb = 1'b0;
    wb_cyc = 1'b0;
  endtask

  task automatic expect_reads(input logic [11:0] adr, input int nwords);
    for (int i = 0; i < nwords; i++) push_mem(1'b0, {adr, 3'(i), 1'b0}, 16'h0, 2'b11);
  endtask

  task automatic set_wait(input int w);
    for (int i = 0; i < 8; i++) mem_wait[i] = w;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_wait(0);
    do_reset();

    // Full-line read, single-cycle memory.
    mem_base = 16'hA000;
    issue(1'b0, 12'h123, 16'hFFFF, 128'h0);
    expect_reads(12'h123, 8);
    push_rsp(1'b0, t0 + 9, 1'b1, 128'hA007_A006_A005_A004_A003_A002_A001_A000);
    wait_ack(30);

    // Sparse write (words 0 and 7), three wait cycles each; line buffer untouched.
    set_wait(3);
    issue(1'b1, 12'h2A5, 16'h8001, 128'h8888_7777_6666_5555_4444_3333_2222_1111);
    push_mem(1'b1, 16'h2A50, 16'h1111, 2'b01);
    push_mem(1'b1, 16'h2A5E, 16'h8888, 2'b10);
    push_rsp(1'b0, t0 + 9, 1'b1, 128'hA007_A006_A005_A004_A003_A002_A001_A000);
    wait_ack(30);

    // Single-word write, then an empty-select write.
    do_reset();
    set_wait(0);
    issue(1'b1, 12'h040, 16'h0030, 128'h0000_0000_0000_0000_0000_BEEF_0000_0000);
    push_mem(1'b1, 16'h0404, 16'hBEEF, 2'b11);
    push_rsp(1'b0, t0 + 2, 1'b1, 128'h0);
    wait_ack(20);
    issue(1'b1, 12'h0FF, 16'h0000, 128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0);
    push_rsp(1'b0, t0 + 1, 1'b1, 128'h0);
    wait_ack(20);

    // Abort: cyc drops while word 2 is stalled; word 2 still lands, no ack.
    do_reset();
    mem_base = 16'hB000;
    set_wait(0);
    mem_wait[2] = 4;
    issue(1'b0, 12'h050, 16'hFFFF, 128'h0);
    expect_reads(12'h050, 3);
    repeat (3) @(negedge clk);
    wb_stb = 1'b0;
    wb_cyc = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_idle_rw", 128'({mem_read, mem_write}), 128'(0));
    check("abort_dat_s", wb_dat_s, 128'h0000_0000_0000_0000_0000_B002_B001_B000);

    // Reset in the middle of a write, then a fresh read with one wait per word.
    do_reset();
    set_wait(2);
    issue(1'b1, 12'h0A0, 16'hFFFF, 128'hF7F7_F6F6_F5F5_F4F4_F3F3_F2F2_F1F1_F0F0);
    push_mem(1'b1, 16'h0A00, 16'hF0F0, 2'b11);
    repeat (4) @(negedge clk);
    do_reset();
    set_wait(1);
    mem_base = 16'h1000;
    issue(1'b0, 12'h7FF, 16'hFFFF, 128'h0);
    expect_reads(12'h7FF, 8);
    push_rsp(1'b0, t0 + 17, 1'b1, 128'h1007_1006_1005_1004_1003_1002_1001_1000);
    wait_ack(40);

    // Refresh collision: with a 16-cycle period the pending flag rises on the
    // 16th rising edge after reset release, so a request raised right after
    // it is retried, waits out 4 refresh cycles and is then served.
    do_reset();
    set_wait(0);
    mem_base = 16'hC000;
    repeat (15) @(negedge clk);
    issue(1'b0, 12'h3C0, 16'hFFFF, 128'h0);
    push_rsp(1'b1, t0 + 1, 1'b0, 128'h0);
    expect_reads(12'h3C0, 8);
    push_rsp(1'b0, t0 + 15, 1'b1, 128'hC007_C006_C005_C004_C003_C002_C001_C000);
    wait_ack(40);

    repeat (4) @(negedge clk);
    check("final_mem_queue", 128'(exp_mem.size()), 128'(0));
    check("final_rsp_queue", 128'(exp_rsp.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

endmodule
